game_reaction_core: RTL and testbench

Core logic for the reaction-time game that sits behind the top-level pins of tt_um_hugoC_game. It synchronizes the start and button pins and waits a pseudo-random delay. It then lights the GO LED and measures the player's response time in ticks. It reports the score, a false-start flag or a timeout to the output pins. It is the responder to the stimulus the cocotb bench drives on ui_in, and it produces what the bench checks on uo_out.

---
 rtl/game_reaction_core_if.sv | 34 +++
 rtl/game_reaction_core.sv | 165 ++++++++++++++++
 tb/tb_game_reaction_core.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_reaction_core_if.sv
// Pin-level bundle for the reaction game core.
// Raw player pins in, registered lamp/score/status out.
interface game_reaction_core_if;
  logic       start_in;
  logic       btn_in;
  logic       led_go;
  logic       busy;
  logic [7:0] result;
  logic       result_valid;
  logic       early;
  logic [1:0] state;

  modport master (
    output start_in,
    output btn_in,
    input  led_go,
    input  busy,
    input  result,
    input  result_valid,
    input  early,
    input  state
  );

  modport slave (
    input  start_in,
    input  btn_in,
    output led_go,
    output busy,
    output result,
    output result_valid,
    output early,
    output state
  );
endinterface

// File: rtl/game_reaction_core.sv
// Reaction-time game core: random wait, GO lamp,
// response measured in ticks, false start / timeout.
module game_reaction_core #(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned DELAY_MIN = 8,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  game_reaction_core_if.slave io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GO   = 2'd2,
    SHOW = 2'd3
  } st_t;

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
  localparam logic [7:0] DMIN = 8'(DELAY_MIN);

  logic [1:0]    sy1, sy2, prv;
  logic [1:0]    rise;
  logic          rise_s, rise_b;
  logic [7:0]    lfsr;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic          enter;

  st_t        st, st_n;
  logic [7:0] dly, dly_n;
  logic [7:0] rcnt, rcnt_n;
  logic [7:0] res, res_n;
  logic       erl, erl_n;
  logic       go_q, busy_q, vld_q;

  assign rise   = sy2 & ~prv & {2{ena}};
  assign rise_s = rise[0];
  assign rise_b = rise[1];
  assign tick   = ena && (tcnt == TMAX);
  assign enter  = (st_n != st) &&
                  (st_n == WAIT || st_n == GO);

  // two-flop synchronizers plus edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sy1 <= '0;
      sy2 <= '0;
      prv <= '0;
    end else if (ena) begin
      sy1 <= {io.btn_in, io.start_in};
      sy2 <= sy1;
      prv <= sy2;
    end
  end

  // free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (ena) begin
      lfsr <= {lfsr[6:0],
               lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // tick prescaler, realigned on WAIT/GO entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (ena) begin
      if (enter || tick) tcnt <= '0;
      else               tcnt <= tcnt + TW'(1);
    end
  end

  // next-state and round datapath
  always_comb begin
    st_n   = st;
    dly_n  = dly;
    rcnt_n = rcnt;
    res_n  = res;
    erl_n  = erl;
    if (ena) begin
      unique case (st)
        IDLE: begin
          if (rise_s) begin
            st_n  = WAIT;
            dly_n = DMIN + {4'd0, lfsr[3:0]};
          end
        end
        WAIT: begin
          if (rise_b) begin
            st_n  = SHOW;
            res_n = 8'hFF;
            erl_n = 1'b1;
          end else if (tick) begin
            if (dly == 8'd1) begin
              st_n   = GO;
              rcnt_n = 8'd0;
            end
            dly_n = dly - 8'd1;
          end
        end
        GO: begin
          if (rise_b) begin
            st_n  = SHOW;
            res_n = rcnt;
            erl_n = 1'b0;
          end else if (tick) begin
            rcnt_n = rcnt + 8'd1;
            if (rcnt == 8'hFE) begin
              st_n  = SHOW;
              res_n = 8'hFF;
              erl_n = 1'b0;
            end
          end
        end
        SHOW: begin
          if (rise_s) begin
            st_n  = WAIT;
            dly_n = DMIN + {4'd0, lfsr[3:0]};
            res_n = 8'd0;
            erl_n = 1'b0;
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  // state register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      dly    <= '0;
      rcnt   <= '0;
      res    <= '0;
      erl    <= 1'b0;
      go_q   <= 1'b0;
      busy_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      st     <= st_n;
      dly    <= dly_n;
      rcnt   <= rcnt_n;
      res    <= res_n;
      erl    <= erl_n;
      go_q   <= (st_n == GO);
      busy_q <= (st_n == WAIT) || (st_n == GO);
      vld_q  <= (st_n == SHOW);
    end
  end

  assign io.led_go       = go_q;
  assign io.busy         = busy_q;
  assign io.result       = res;
  assign io.result_valid = vld_q;
  assign io.early        = erl;
  assign io.state        = st;

endmodule

// File: tb/tb_game_reaction_core.sv
// Bench for game_reaction_core: directed rounds plus
// random rounds against a tick-arithmetic round model.
module tb_game_reaction_core;

  localparam int TD = 4;
  localparam int DM = 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;

  game_reaction_core_if io();

  game_reaction_core #(
    .TICK_DIV (TD),
    .DELAY_MIN(DM),
    .LFSR_SEED(SEED)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .io   (io)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;
  bit led_seen;

  // round model: phase 0 idle, 1 wait, 2 go, 3 show
  int         m_ph;
  int         m_cyc;
  int         m_dly;
  int         m_res;
  bit         m_early;
  logic [7:0] m_lfsr;
  logic [2:0] hs, hb;

  function automatic logic [7:0] lfsr_step(logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph    = 0;
    m_cyc   = 0;
    m_dly   = 0;
    m_res   = 0;
    m_early = 0;
    m_lfsr  = SEED;
    hs      = '0;
    hb      = '0;
  endtask

  task automatic enter_wait();
    m_ph    = 1;
    m_dly   = DM + int'(m_lfsr[3:0]);
    m_cyc   = 0;
    m_res   = 0;
    m_early = 0;
  endtask

  // one enabled clock edge; hs/hb[k] = pin k+1 edges ago
  task automatic model_edge(bit s, bit b);
    bit rs, rb;
    rs = hs[1] && !hs[2];
    rb = hb[1] && !hb[2];
    case (m_ph)
      0: if (rs) enter_wait();
      1: begin
        if (rb) begin
          m_ph = 3; m_res = 255; m_early = 1;
        end else begin
          m_cyc++;
          if (m_cyc == m_dly * TD) begin
            m_ph = 2; m_cyc = 0;
          end
        end
      end
      2: begin
        if (rb) begin
          m_ph = 3; m_res = m_cyc / TD; m_early = 0;
        end else begin
          m_cyc++;
          if (m_cyc == 255 * TD) begin
            m_ph = 3; m_res = 255; m_early = 0;
          end
        end
      end
      default: if (rs) enter_wait();
    endcase
    m_lfsr = lfsr_step(m_lfsr);
    hs = {hs[1:0], s};
    hb = {hb[1:0], b};
  endtask

  function automatic logic [13:0] exp_vec();
    return {2'(m_ph), m_ph == 2, m_ph == 1 || m_ph == 2,
            m_ph == 3, m_early, 8'(m_res)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {io.state, io.led_go, io.busy,
            io.result_valid, io.early, io.result};
  endfunction

  task automatic cyc(bit s, bit b);
    io.start_in = s;
    io.btn_in   = b;
    @(posedge clk);
    if (!rst_n)   model_reset();
    else if (ena) model_edge(s, b);
    @(negedge clk);
    ncyc++;
    if (io.led_go) led_seen = 1;
    check("outputs", dut_vec(), exp_vec());
  endtask

  task automatic run_until(logic [1:0] st, int max,
                           string tag, bit s, bit b);
    int n = 0;
    while (io.state !== st && n < max) begin
      cyc(s, b);
      n++;
    end
    check(tag, io.state, st);
  endtask

  initial begin
    int tw, tg, d, n;
    logic [13:0] saved;
    io.start_in = 0;
    io.btn_in   = 0;
    model_reset();

    // reset and quiet idle
    rst_n = 0;
    ena   = 1;
    repeat (5) cyc(0, 0);
    check("reset_vec", dut_vec(), 14'd0);
    rst_n = 1;
    repeat (100) cyc(0, 0);
    check("idle_vec", dut_vec(), 14'd0);

    // normal round
    tw = -1; tg = -1; n = 0;
    repeat (3) begin
      cyc(1, 0);
      if (io.state == 2'd1 && tw < 0) tw = ncyc;
    end
    check("wait_entry", io.busy, 1);
    while (!io.led_go && n < 200) begin
      cyc(0, 0);
      if (io.state == 2'd1 && tw < 0) tw = ncyc;
      n++;
    end
    check("go_seen", io.led_go, 1);
    tg = ncyc;
    d  = tg - tw;
    check("go_delay_range", d >= 32 && d <= 92, 1);
    repeat (40) cyc(0, 0);
    cyc(0, 1);
    run_until(2'd3, 10, "normal_show", 0, 0);
    check("normal_early", io.early, 0);
    check("normal_score",
          io.result >= 9 && io.result <= 11, 1);

    // false start
    led_seen = 0;
    repeat (2) cyc(1, 0);
    run_until(2'd1, 5, "fs_wait", 0, 0);
    repeat ($urandom_range(3, 20)) cyc(0, 0);
    cyc(0, 1);
    run_until(2'd3, 10, "fs_show", 0, 0);
    check("fs_early", io.early, 1);
    check("fs_result", io.result, 8'hFF);
    check("fs_no_lamp", led_seen, 0);

    // timeout
    cyc(1, 0);
    run_until(2'd2, 120, "to_go", 0, 0);
    run_until(2'd3, 1100, "to_show", 0, 0);
    check("to_result", io.result, 8'hFF);
    check("to_early", io.early, 0);
    check("to_valid", io.result_valid, 1);

    // replay: start and btn together, btn held
    repeat (3) cyc(1, 1);
    run_until(2'd1, 5, "replay_wait", 0, 1);
    check("replay_valid", io.result_valid, 0);
    repeat (60) cyc(0, 1);
    check("held_btn_busy", io.busy, 1);
    check("held_btn_early", io.early, 0);
    run_until(2'd2, 120, "replay_go", 0, 1);
    repeat (5) cyc(0, 0);
    cyc(0, 1);
    run_until(2'd3, 10, "replay_show", 0, 0);
    check("replay_score", io.result < 8'hFF, 1);

    // freeze in GO, then keep scoring
    cyc(1, 0);
    run_until(2'd2, 120, "frz_go", 0, 0);
    repeat (7) cyc(0, 0);
    saved = dut_vec();
    ena = 0;
    for (int i = 0; i < 50; i++) cyc(0, i >= 20 && i < 23);
    check("freeze_hold", dut_vec(), saved);
    ena = 1;
    repeat (6) cyc(0, 0);
    check("freeze_still_go", io.led_go, 1);
    cyc(0, 1);
    run_until(2'd3, 10, "frz_show", 0, 0);

    // asynchronous reset mid-GO
    cyc(1, 0);
    run_until(2'd2, 120, "ar_go", 0, 0);
    repeat (5) cyc(0, 0);
    #1 rst_n = 0;
    #1;
    check("async_led", io.led_go, 0);
    check("async_state", io.state, 2'd0);
    model_reset();
    repeat (3) cyc(0, 0);
    rst_n = 1;
    repeat (5) cyc(0, 0);

    // random rounds with enable gaps
    for (int r = 0; r < 25; r++) begin
      int wt, pl;
      repeat ($urandom_range(1, 4)) cyc(1, 0);
      wt = $urandom_range(0, 140);
      pl = $urandom_range(1, 3);
      for (int i = 0; i < wt; i++) begin
        ena = ($urandom_range(0, 7) != 0);
        cyc($urandom_range(0, 15) == 0, 0);
      end
      ena = 1;
      repeat (pl) cyc(0, 1);
      n = 0;
      while (io.state !== 2'd3 && n < 1200) begin
        cyc(0, 0);
        n++;
      end
      check("rnd_show", io.state, 2'd3);
      repeat ($urandom_range(1, 6)) cyc(0, 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
